// File: rtl/hsel_slave_bank.sv
// hsel_slave_bank: three AHB-style slave banks of four 16-bit registers each,
// with slave-3 wait-state insertion and a two-cycle error response for
// decoder selects that are not one-hot.
module hsel_slave_bank #(
  parameter int          WAIT_S3 = 2,
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel_1,
  input  logic        hsel_2,
  input  logic        hsel_3,
  input  logic [15:0] haddr,
  input  logic        hwrite,
  input  logic [15:0] hwdata,
  input  logic        valid,
  output logic        hready,
  output logic [15:0] hrdata,
  output logic        hresp,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    WAIT = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } state_t;

  localparam logic       HAS_WAIT  = (WAIT_S3 > 0);
  localparam logic [2:0] WAIT_LOAD = HAS_WAIT ? 3'(WAIT_S3 - 1) : 3'd0;

  state_t      state;
  state_t      state_next;
  logic [2:0]  sel_in;
  logic        sel_ok;
  logic        accept;
  logic [2:0]  sel_q;
  logic [1:0]  idx_q;
  logic        write_q;
  logic [15:0] wdata_q;
  logic [2:0]  wait_cnt;
  logic [1:0]  bank;
  logic [3:0]  reg_idx;
  logic [15:0] regs [12];
  logic        unused_addr;

  // Only the register index bits of the address word are meaningful here.
  assign unused_addr = ^haddr[15:2];

  assign sel_in = {hsel_3, hsel_2, hsel_1};
  assign sel_ok = (sel_in == 3'b001) || (sel_in == 3'b010) || (sel_in == 3'b100);
  assign accept = (state == IDLE) && valid;

  // Flat register index from the latched one-hot select and register index.
  always_comb begin
    bank = 2'd0;
    if (sel_q[1]) bank = 2'd1;
    else if (sel_q[2]) bank = 2'd2;
    reg_idx = {bank, idx_q};
  end

  // State register; reset drops any transfer in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus the handshake outputs, which depend on state only.
  always_comb begin
    state_next = state;
    hready     = 1'b1;
    hresp      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          if (!sel_ok)                 state_next = ERR1;
          else if (hsel_3 && HAS_WAIT) state_next = WAIT;
          else                         state_next = DATA;
        end
      end
      WAIT: begin
        hready = 1'b0;
        if (wait_cnt == 3'd0) state_next = DATA;
      end
      DATA: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR1: begin
        hready     = 1'b0;
        hresp      = 1'b1;
        state_next = ERR2;
      end
      ERR2: begin
        hresp      = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the request at the accept edge so later bus changes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 3'b000;
      idx_q   <= 2'd0;
      write_q <= 1'b0;
      wdata_q <= 16'h0000;
    end else if (accept) begin
      sel_q   <= sel_in;
      idx_q   <= haddr[1:0];
      write_q <= hwrite;
      wdata_q <= hwdata;
    end
  end

  // Wait counter: loaded when a slave-3 access is accepted, counts down, sticks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 3'd0;
    end else if (accept && state_next == WAIT) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == WAIT && wait_cnt != 3'd0) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Register banks change only when a write completes in the data phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) regs[i] <= RST_VAL;
    end else if (state == DATA && write_q) begin
      regs[reg_idx] <= wdata_q;
    end
  end

  // Read data holds until the next successful read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hrdata <= 16'h0000;
    end else if (state == DATA && !write_q) begin
      hrdata <= regs[reg_idx];
    end
  end

endmodule

// File: tb/tb_hsel_slave_bank.sv
// Testbench for hsel_slave_bank: directed transfers checked against a
// reference register model through an expected-transfer queue.
module tb_hsel_slave_bank;

  localparam int          WAIT_S3 = 2;
  localparam logic [15:0] RST_VAL = 16'h0000;

  typedef struct {
    int          accept_cyc;
    int          done_cyc;
    logic        err;
    logic        wr;
    logic [15:0] rdata;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        hsel_1, hsel_2, hsel_3;
  logic [15:0] haddr;
  logic        hwrite;
  logic [15:0] hwdata;
  logic        valid;
  logic        hready;
  logic [15:0] hrdata;
  logic        hresp;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  txn_t        q[$];
  txn_t        head;
  logic [15:0] model [12];
  logic [15:0] exp_hrdata;
  logic        hr_pending;

  hsel_slave_bank #(.WAIT_S3(WAIT_S3), .RST_VAL(RST_VAL)) dut (
    .clk    (clk),
    .rst    (rst),
    .hsel_1 (hsel_1),
    .hsel_2 (hsel_2),
    .hsel_3 (hsel_3),
    .haddr  (haddr),
    .hwrite (hwrite),
    .hwdata (hwdata),
    .valid  (valid),
    .hready (hready),
    .hrdata (hrdata),
    .hresp  (hresp),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle count used to time-stamp accepts and completions.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic driveBus(input logic [2:0] sel, input logic [15:0] addr,
                          input logic wr, input logic [15:0] wdata, input logic v);
    {hsel_3, hsel_2, hsel_1} = sel;
    haddr  = addr;
    hwrite = wr;
    hwdata = wdata;
    valid  = v;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 12; i++) model[i] = RST_VAL;
    exp_hrdata = 16'h0000;
    hr_pending = 1'b0;
    q.delete();
  endtask

  // Predict the outcome of a transfer and queue it for the monitor.
  task automatic pushTxn(input logic [2:0] sel, input logic [15:0] addr,
                         input logic wr, input logic [15:0] wdata, input int accept);
    txn_t t;
    int   b;
    int   lat;
    t.accept_cyc = accept;
    t.err   = !(sel == 3'b001 || sel == 3'b010 || sel == 3'b100);
    t.wr    = wr;
    t.rdata = 16'h0000;
    if (t.err)         lat = 2;
    else if (sel[2])   lat = 1 + WAIT_S3;
    else               lat = 1;
    t.done_cyc = accept + lat - 1;
    if (!t.err) begin
      b = (sel == 3'b001) ? 0 : (sel == 3'b010) ? 1 : 2;
      if (wr) model[b*4 + int'(addr[1:0])] = wdata;
      else    t.rdata = model[b*4 + int'(addr[1:0])];
    end
    q.push_back(t);
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((q.size() != 0 || hr_pending) && n < 40);
    if (q.size() != 0 || hr_pending) begin
      checkOutput("idle_timeout", 32'(q.size()) + 32'(hr_pending), 32'd0);
      q.delete();
      hr_pending = 1'b0;
    end
  endtask

  // One complete transfer: drive for the accept edge, then scramble the bus.
  task automatic applyStimulus(input logic [2:0] sel, input logic [15:0] addr,
                               input logic wr, input logic [15:0] wdata);
    driveBus(sel, addr, wr, wdata, 1'b1);
    pushTxn(sel, addr, wr, wdata, cyc + 1);
    @(negedge clk);
    #1;
    driveBus(~sel, ~addr, ~wr, ~wdata, 1'b0);
    waitIdle();
  endtask

  // Monitor: compare handshake outputs and completion timing against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (hr_pending) begin
        checkOutput("hrdata", 32'(hrdata), 32'(exp_hrdata));
        hr_pending = 1'b0;
      end
      if (q.size() != 0 && cyc >= q[0].accept_cyc) begin
        head = q[0];
        if (done) begin
          checkOutput("done_cycle", cyc, head.done_cyc);
          checkOutput("hresp_done", 32'(hresp), 32'(head.err));
          checkOutput("hready_done", 32'(hready), 32'd1);
          if (!head.err && !head.wr) exp_hrdata = head.rdata;
          hr_pending = 1'b1;
          void'(q.pop_front());
        end else if (cyc >= head.done_cyc) begin
          checkOutput("done_late", cyc, head.done_cyc + 1);
          void'(q.pop_front());
        end else begin
          checkOutput("hready_busy", 32'(hready), 32'd0);
          checkOutput("hresp_busy", 32'(hresp), 32'(head.err));
        end
      end else begin
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_hresp", 32'(hresp), 32'd0);
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1;
    driveBus(3'b000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    resetModel();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_hready", 32'(hready), 32'd1);
    checkOutput("rst_hresp", 32'(hresp), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_hrdata", 32'(hrdata), 32'd0);
    rst = 1'b0;

    // Write then read slave 1; the write is accepted on the first edge after reset.
    applyStimulus(3'b001, 16'h0002, 1'b1, 16'h4008);
    applyStimulus(3'b001, 16'h0002, 1'b0, 16'h0000);

    // Slave 3 read with wait states.
    applyStimulus(3'b100, 16'h0000, 1'b0, 16'h0000);

    // Illegal selects, then readback of slaves 1 and 2.
    applyStimulus(3'b000, 16'h0002, 1'b1, 16'hFFFF);
    applyStimulus(3'b011, 16'h0002, 1'b1, 16'hFFFF);
    applyStimulus(3'b001, 16'h0002, 1'b0, 16'h0000);
    applyStimulus(3'b010, 16'h0002, 1'b0, 16'h0000);

    // Bank isolation at a shared index.
    applyStimulus(3'b001, 16'h0001, 1'b1, 16'h0001);
    applyStimulus(3'b010, 16'h0001, 1'b1, 16'h0002);
    applyStimulus(3'b100, 16'h0001, 1'b1, 16'h0003);
    applyStimulus(3'b001, 16'h0001, 1'b0, 16'h0000);
    applyStimulus(3'b010, 16'h0001, 1'b0, 16'h0000);
    applyStimulus(3'b100, 16'h0001, 1'b0, 16'h0000);

    // valid held high through a slave 3 access; the second request waits for IDLE.
    base = cyc + 1;
    driveBus(3'b100, 16'h0000, 1'b0, 16'h0000, 1'b1);
    pushTxn(3'b100, 16'h0000, 1'b0, 16'h0000, base);
    @(negedge clk);
    #1;
    driveBus(3'b001, 16'h0003, 1'b1, 16'hBEEF, 1'b1);
    pushTxn(3'b001, 16'h0003, 1'b1, 16'hBEEF, base + WAIT_S3 + 2);
    repeat (WAIT_S3 + 2) @(negedge clk);
    #1;
    driveBus(3'b000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    waitIdle();
    applyStimulus(3'b001, 16'h0003, 1'b0, 16'h0000);

    // Reset pulsed while a slave 3 write sits in its wait states.
    driveBus(3'b100, 16'h0001, 1'b1, 16'h0008, 1'b1);
    pushTxn(3'b100, 16'h0001, 1'b1, 16'h0008, cyc + 1);
    @(negedge clk);
    #1;
    driveBus(3'b000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_hready", 32'(hready), 32'd1);
    checkOutput("midrst_hresp", 32'(hresp), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_hrdata", 32'(hrdata), 32'd0);
    resetModel();
    #1;
    rst = 1'b0;
    applyStimulus(3'b100, 16'h0001, 1'b0, 16'h0000);
    applyStimulus(3'b001, 16'h0002, 1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsel_slave_bank.md
HSEL_SLAVE_BANK -- requirements
Module: hsel_slave_bank

Interface
REQ-001 Parameter WAIT_S3, default 2, SHALL set the number of wait cycles inserted for slave 3 accesses (legal range 0..7).
REQ-002 Parameter RST_VAL, default 16'h0000, SHALL set the reset value of every slave register.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 hsel_1, hsel_2, hsel_3  input  1 each  slave selects from the upstream decoder.
REQ-006 haddr  input  16  word from the upstream PIPO; only haddr[1:0] SHALL be used, as the register index.
REQ-007 hwrite  input  1  1 = write, 0 = read.
REQ-008 hwdata  input  16  write data.
REQ-009 valid  input  1  transfer request, sampled only when hready=1.
REQ-010 hready  output  1  1 = idle or completing; 0 = busy.
REQ-011 hrdata  output  16  read data of the last completed read.
REQ-012 hresp  output  1  1 = error response.
REQ-013 done  output  1  one-cycle pulse on every transfer completion, including errors.

Function
REQ-014 The block SHALL hold three banks (slave 1..3), each of four 16-bit registers.
REQ-015 FSM states SHALL be IDLE, DATA, WAIT, ERR1 and ERR2.
REQ-016 In IDLE, hready=1, and a rising edge with valid=1 SHALL accept the transfer: latch the hsel vector, haddr[1:0], hwrite and hwdata.
REQ-017 After acceptance, the FSM SHALL go to:
- ERR1 if the latched hsel vector is not exactly one-hot (none set, or more than one set);
- WAIT if hsel_3 is set and WAIT_S3>0;
- DATA otherwise.
REQ-018 WAIT SHALL load a counter with WAIT_S3-1 on entry, decrement it once per cycle, and exit to DATA on the cycle the counter reads 0.
REQ-019 The counter SHALL be 3 bits wide and SHALL never wrap below 0.
REQ-020 In DATA, hready SHALL be 1, done SHALL be 1, and on the next edge:
- a write SHALL update the selected register;
- a read SHALL load hrdata with the selected register;
- the FSM SHALL return to IDLE.
REQ-021 Latency from the accept edge to done=1 SHALL be 1 cycle for slave 1/2 and 1+WAIT_S3 cycles for slave 3.
REQ-022 In ERR1, hresp SHALL be 1 and hready SHALL be 0. In ERR2, hresp SHALL be 1, hready SHALL be 1 and done SHALL be 1. ERR1 SHALL be followed by ERR2, then IDLE.
REQ-023 An erroneous transfer SHALL modify no register and SHALL leave hrdata unchanged.
REQ-024 valid SHALL be ignored in every state other than IDLE; back-to-back requests SHALL therefore cost at least one IDLE cycle between them.
REQ-025 hrdata SHALL hold its value until the next successful read completes.
REQ-026 Changes on the hsel_*, haddr, hwrite and hwdata inputs after the accept edge SHALL NOT affect the accepted transfer.
REQ-027 In every state other than ERR1/ERR2, hresp SHALL be 0.

Reset
REQ-028 While rst=1, the following SHALL be forced immediately, regardless of clk:
- FSM to IDLE;
- hready=1, hresp=0, done=0, hrdata=16'h0000;
- all twelve registers to RST_VAL;
- the wait counter to 0.
REQ-029 A reset asserted mid-transfer SHALL abort that transfer with no register write and no done pulse.
REQ-030 The first request SHALL be accepted on the first rising edge after rst deasserts with valid=1.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- Write then read, slave 1: hsel_1=1, haddr=16'h0002, hwrite=1, hwdata=16'h4008, valid=1, then read of the same address -> done 1 cycle after each accept; hrdata=16'h4008; hresp=0.
- Slave 3 wait states, WAIT_S3=2: read of slave 3, index 0, after reset -> hready=0 for 2 cycles, then done=1 and hrdata=16'h0000, 3 cycles after accept.
- Illegal selects: hsel vector 3'b000, then 3'b011, each with a write of 16'hFFFF -> hresp=1 for 2 cycles, hready 0 then 1, done in the second cycle; a readback of slaves 1/2 shows the data unchanged.
- Ignored request: valid held high while hready=0 during a slave 3 access -> exactly one transfer completes; the next transfer is accepted only after the IDLE cycle.
- Reset mid-access: rst pulsed during the WAIT state of a slave 3 write of 16'h0008 -> outputs at their reset values before the next clk edge; a later read returns RST_VAL.
- Bank isolation: the same index written with 16'h0001, 16'h0002 and 16'h0003 in slaves 1, 2 and 3 -> each slave reads back its own value.
